// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared FSM type, width helpers and byte merge for the write-through dcache
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  function automatic int ofs_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words_per_line);
    return 32 - 2 - ofs_w(words_per_line) - idx_w(lines);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = sel[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/tag/data storage, combinational read, byte-masked synchronous write
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [idx_w(LINES)-1:0]               idx,
  input  logic [ofs_w(WORDS_PER_LINE)-1:0]      ofs,
  output logic                                  rd_valid,
  output logic [tag_w(LINES,WORDS_PER_LINE)-1:0] rd_tag,
  output logic [31:0]                           rd_data,
  input  logic                                  valid_clr,
  input  logic                                  tag_we,
  input  logic [tag_w(LINES,WORDS_PER_LINE)-1:0] tag_wdata,
  input  logic                                  data_we,
  input  logic [ofs_w(WORDS_PER_LINE)-1:0]      data_ofs,
  input  logic [31:0]                           data_wdata,
  input  logic [3:0]                            data_sel
);

  localparam int OFS_W = ofs_w(WORDS_PER_LINE);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, WORDS_PER_LINE);

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags [LINES];
  logic [31:0]        data [LINES*WORDS_PER_LINE];
  logic [IDX_W+OFS_W-1:0] rd_addr;
  logic [IDX_W+OFS_W-1:0] wr_addr;

  assign rd_addr  = {idx, ofs};
  assign wr_addr  = {idx, data_ofs};
  assign rd_valid = valid[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = data[rd_addr];

  // Setting valid on the final refill word wins over any clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[idx] <= 1'b1;
    end else if (valid_clr) begin
      valid[idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tags[idx] <= tag_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data[wr_addr] <= byte_merge(data[wr_addr], data_wdata, data_sel);
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - direct-mapped write-through no-write-allocate data cache, Mcache responder
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MCACHE_ADR_VALID_SM,
  input  logic [31:0] MCACHE_ADR_SM,
  input  logic        MCACHE_LOAD_SM,
  input  logic        MCACHE_STORE_SM,
  input  logic [31:0] MCACHE_DATA_SM,
  input  logic [3:0]  byt_sel,
  output logic [31:0] MCACHE_RESULT_SM,
  output logic        MCACHE_STALL_SM,
  output logic [31:0] RAM_ADR_SC,
  output logic [31:0] RAM_WDATA_SC,
  output logic [3:0]  RAM_BYTE_SEL_SC,
  output logic        RAM_RE_SC,
  output logic        RAM_WE_SC,
  input  logic [31:0] RAM_RDATA_SR,
  input  logic        RAM_ACK_SR
);

  localparam int OFS_W = ofs_w(WORDS_PER_LINE);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, WORDS_PER_LINE);

  state_t           state;
  logic [OFS_W-1:0] cnt;

  logic [OFS_W-1:0] adr_ofs;
  logic [IDX_W-1:0] adr_idx;
  logic [TAG_W-1:0] adr_tag;
  logic             unused_adr_bits;

  assign adr_ofs         = MCACHE_ADR_SM[2 +: OFS_W];
  assign adr_idx         = MCACHE_ADR_SM[2+OFS_W +: IDX_W];
  assign adr_tag         = MCACHE_ADR_SM[31 -: TAG_W];
  assign unused_adr_bits = ^MCACHE_ADR_SM[1:0];

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             req, is_store, hit, last_word;
  logic             in_refill, ack_refill, ack_write;

  assign req        = MCACHE_ADR_VALID_SM & (MCACHE_LOAD_SM | MCACHE_STORE_SM);
  assign is_store   = MCACHE_STORE_SM;
  assign hit        = rd_valid & (rd_tag == adr_tag);
  assign last_word  = &cnt;
  assign in_refill  = (state == REFILL);
  assign ack_refill = in_refill & RAM_ACK_SR;
  assign ack_write  = (state == WRITE) & RAM_ACK_SR;

  // The line is invalidated as the refill starts so its partial contents never hit.
  dcache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .idx        (adr_idx),
    .ofs        (adr_ofs),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .valid_clr  (~reset & (state == IDLE) & req & ~is_store & ~hit),
    .tag_we     (~reset & ack_refill & last_word),
    .tag_wdata  (adr_tag),
    .data_we    (~reset & (ack_refill | (ack_write & hit))),
    .data_ofs   (in_refill ? cnt : adr_ofs),
    .data_wdata (in_refill ? RAM_RDATA_SR : MCACHE_DATA_SM),
    .data_sel   (in_refill ? 4'hF : byt_sel)
  );

  always_comb begin
    MCACHE_STALL_SM  = 1'b1;
    MCACHE_RESULT_SM = '0;
    RAM_RE_SC        = 1'b0;
    RAM_WE_SC        = 1'b0;
    RAM_ADR_SC       = {MCACHE_ADR_SM[31:2], 2'b00};
    RAM_WDATA_SC     = MCACHE_DATA_SM;
    RAM_BYTE_SEL_SC  = byt_sel;
    if (!reset) begin
      case (state)
        IDLE: begin
          MCACHE_STALL_SM = req & (is_store | ~hit);
          if (req & ~is_store & hit) begin
            MCACHE_RESULT_SM = rd_data;
          end
        end
        REFILL: begin
          RAM_RE_SC  = 1'b1;
          RAM_ADR_SC = {adr_tag, adr_idx, cnt, 2'b00};
        end
        WRITE: begin
          RAM_WE_SC       = 1'b1;
          MCACHE_STALL_SM = ~RAM_ACK_SR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (is_store) begin
              state <= WRITE;
            end else if (!hit) begin
              state <= REFILL;
              cnt   <= '0;
            end
          end
        end
        REFILL: begin
          if (RAM_ACK_SR) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              state <= IDLE;
            end
          end
        end
        WRITE: begin
          if (RAM_ACK_SR) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// tb/tb_dcache_wt.sv - directed self-checking bench for dcache_wt
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        reset;
  logic        adr_valid;
  logic [31:0] adr;
  logic        load, store;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [31:0] result;
  logic        stall;
  logic [31:0] ram_adr, ram_wdata;
  logic [3:0]  ram_sel;
  logic        ram_re, ram_we;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_wt #(.LINES(64), .WORDS_PER_LINE(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .MCACHE_ADR_VALID_SM (adr_valid),
    .MCACHE_ADR_SM       (adr),
    .MCACHE_LOAD_SM      (load),
    .MCACHE_STORE_SM     (store),
    .MCACHE_DATA_SM      (wdata),
    .byt_sel             (sel),
    .MCACHE_RESULT_SM    (result),
    .MCACHE_STALL_SM     (stall),
    .RAM_ADR_SC          (ram_adr),
    .RAM_WDATA_SC        (ram_wdata),
    .RAM_BYTE_SEL_SC     (ram_sel),
    .RAM_RE_SC           (ram_re),
    .RAM_WE_SC           (ram_we),
    .RAM_RDATA_SR        (ram_rdata),
    .RAM_ACK_SR          (ram_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req_load(input logic [31:0] a);
    adr_valid = 1'b1; adr = a; load = 1'b1; store = 1'b0;
  endtask

  task automatic req_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    adr_valid = 1'b1; adr = a; load = 1'b0; store = 1'b1; wdata = d; sel = s;
  endtask

  // Entered one step after the edge that moved the DUT into REFILL; RAM word w is {4{b0+w}}.
  task automatic refill(input logic [31:0] base, input logic [7:0] b0, input int gap, input int rd_word);
    logic [7:0] bv;
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g < gap; g++) begin
        #1;
        chk("rf_gap_re", {31'd0, ram_re}, 32'd1);
        chk("rf_gap_adr", ram_adr, base + 32'(4*w));
        chk("rf_gap_stall", {31'd0, stall}, 32'd1);
        cyc();
      end
      bv = b0 + 8'(w);
      ram_ack = 1'b1; ram_rdata = {4{bv}};
      #1;
      chk("rf_ack_adr", ram_adr, base + 32'(4*w));
      chk("rf_ack_re", {31'd0, ram_re}, 32'd1);
      chk("rf_ack_we", {31'd0, ram_we}, 32'd0);
      chk("rf_ack_stall", {31'd0, stall}, 32'd1);
      cyc();
      ram_ack = 1'b0; ram_rdata = '0;
    end
    bv = b0 + 8'(rd_word);
    #1;
    chk("rf_done_stall", {31'd0, stall}, 32'd0);
    chk("rf_done_result", result, {4{bv}});
    chk("rf_done_re", {31'd0, ram_re}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; adr_valid = 1'b0; adr = '0; load = 1'b0; store = 1'b0;
    wdata = '0; sel = '0; ram_rdata = '0; ram_ack = 1'b0;
    cyc(); cyc();

    req_load(32'h100); #1;
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_re", {31'd0, ram_re}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_result", result, 32'd0);
    cyc(); reset = 1'b0; #1;
    chk("miss_stall", {31'd0, stall}, 32'd1);
    chk("miss_result", result, 32'd0);
    chk("miss_idle_re", {31'd0, ram_re}, 32'd0);
    cyc();
    refill(32'h100, 8'hA0, 2, 0);
    cyc(); req_load(32'h108); #1;
    chk("hit_stall", {31'd0, stall}, 32'd0);
    chk("hit_result", result, 32'hA2A2A2A2);
    chk("hit_re", {31'd0, ram_re}, 32'd0);

    cyc(); req_store(32'h104, 32'h11223344, 4'b0011); #1;
    chk("st_idle_stall", {31'd0, stall}, 32'd1);
    chk("st_idle_we", {31'd0, ram_we}, 32'd0);
    chk("st_idle_adr", ram_adr, 32'h104);
    chk("st_idle_wdata", ram_wdata, 32'h11223344);
    chk("st_idle_sel", {28'd0, ram_sel}, 32'h3);
    cyc(); #1;
    chk("st_we", {31'd0, ram_we}, 32'd1);
    chk("st_re", {31'd0, ram_re}, 32'd0);
    chk("st_stall", {31'd0, stall}, 32'd1);
    chk("st_sel", {28'd0, ram_sel}, 32'h3);
    cyc(); ram_ack = 1'b1; #1;
    chk("st_ack_stall", {31'd0, stall}, 32'd0);
    chk("st_ack_we", {31'd0, ram_we}, 32'd1);
    cyc(); ram_ack = 1'b0; req_load(32'h104); #1;
    chk("merge_result", result, 32'hA1A13344);
    chk("merge_stall", {31'd0, stall}, 32'd0);
    chk("merge_re", {31'd0, ram_re}, 32'd0);

    cyc(); req_store(32'h2000, 32'hCAFEF00D, 4'hF); #1;
    chk("nwa_idle_stall", {31'd0, stall}, 32'd1);
    cyc(); ram_ack = 1'b1; #1;
    chk("nwa_we", {31'd0, ram_we}, 32'd1);
    chk("nwa_re", {31'd0, ram_re}, 32'd0);
    chk("nwa_adr", ram_adr, 32'h2000);
    chk("nwa_stall", {31'd0, stall}, 32'd0);
    cyc(); ram_ack = 1'b0; req_load(32'h2000); #1;
    chk("nwa_load_miss", {31'd0, stall}, 32'd1);
    chk("nwa_load_result", result, 32'd0);
    cyc();
    refill(32'h2000, 8'hB0, 0, 0);

    cyc(); req_load(32'h100); #1;
    chk("cf_first_stall", {31'd0, stall}, 32'd0);
    chk("cf_first_result", result, 32'hA0A0A0A0);
    cyc(); req_load(32'h500); #1;
    chk("cf_second_miss", {31'd0, stall}, 32'd1);
    cyc();
    refill(32'h500, 8'hC0, 1, 0);
    cyc(); req_load(32'h100); #1;
    chk("cf_evicted_miss", {31'd0, stall}, 32'd1);
    cyc();
    refill(32'h100, 8'hD0, 0, 0);

    cyc(); req_load(32'h300); #1;
    chk("rr_miss", {31'd0, stall}, 32'd1);
    cyc(); ram_ack = 1'b1; ram_rdata = 32'hE0E0E0E0; #1;
    chk("rr_ack0_adr", ram_adr, 32'h300);
    cyc(); ram_rdata = 32'hE1E1E1E1; reset = 1'b1; #1;
    chk("rr_reset_re", {31'd0, ram_re}, 32'd0);
    chk("rr_reset_we", {31'd0, ram_we}, 32'd0);
    chk("rr_reset_stall", {31'd0, stall}, 32'd1);
    chk("rr_reset_result", result, 32'd0);
    cyc(); reset = 1'b0; ram_ack = 1'b0; ram_rdata = '0; #1;
    chk("rr_after_re", {31'd0, ram_re}, 32'd0);
    chk("rr_after_miss", {31'd0, stall}, 32'd1);
    cyc();
    refill(32'h300, 8'hF0, 0, 0);
    cyc(); req_load(32'h100); #1;
    chk("rr_inval_100", {31'd0, stall}, 32'd1);
    #1; adr_valid = 1'b0;

    cyc(); ram_ack = 1'b1; ram_rdata = $urandom; adr = 32'h300; #1;
    chk("nv_stall", {31'd0, stall}, 32'd0);
    chk("nv_result", result, 32'd0);
    chk("nv_re", {31'd0, ram_re}, 32'd0);
    chk("nv_we", {31'd0, ram_we}, 32'd0);
    cyc(); ram_ack = 1'b0; req_load(32'h300); #1;
    chk("nv_hit_stall", {31'd0, stall}, 32'd0);
    chk("nv_hit_result", result, 32'hF0F0F0F0);

    cyc(); req_store(32'h308, 32'h55667788, 4'hF); load = 1'b1; #1;
    chk("ls_idle_stall", {31'd0, stall}, 32'd1);
    chk("ls_idle_re", {31'd0, ram_re}, 32'd0);
    cyc(); #1;
    chk("ls_we", {31'd0, ram_we}, 32'd1);
    chk("ls_re", {31'd0, ram_re}, 32'd0);
    chk("ls_adr", ram_adr, 32'h308);
    cyc(); ram_ack = 1'b1; #1;
    chk("ls_ack_stall", {31'd0, stall}, 32'd0);
    cyc(); ram_ack = 1'b0; req_load(32'h308); #1;
    chk("ls_load_result", result, 32'h55667788);
    chk("ls_load_stall", {31'd0, stall}, 32'd0);
    cyc(); adr_valid = 1'b0; #1;
    chk("end_stall", {31'd0, stall}, 32'd0);
    chk("end_result", result, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
